// File: rtl/mci_burst_bridge_pkg.sv
// Memory controller interface package for the cache-to-external-bus bridge.
// Holds the cache-side request/response structs, the external command
// bundle, the bridge FSM state encoding and a line-alignment helper.
package mci_burst_bridge_pkg;

  localparam int MCI_DATA_LENGTH         = 128;
  localparam int MCI_ADDR_LENGTH         = 32;
  localparam int EXT_DATA_LENGTH_DEFAULT = 32;

  // Clears the byte-offset-within-line bits of an address.
  localparam logic [MCI_ADDR_LENGTH-1:0] LINE_MASK =
    ~(MCI_ADDR_LENGTH'(MCI_DATA_LENGTH / 8) - MCI_ADDR_LENGTH'(1));

  typedef struct packed {
    logic [MCI_ADDR_LENGTH-1:0] addr;
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       rw;     // 1 = write, 0 = read
    logic                       valid;  // one-cycle strobe
  } mci_request_t;

  typedef struct packed {
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       ready;  // one-cycle completion pulse
  } mci_response_t;

  typedef struct packed {
    logic                               valid;
    logic                               we;
    logic [MCI_ADDR_LENGTH-1:0]         addr;
    logic [EXT_DATA_LENGTH_DEFAULT-1:0] wdata;
  } ext_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2,
    RESP    = 2'd3
  } state_t;

  function automatic logic [MCI_ADDR_LENGTH-1:0] line_base(
    input logic [MCI_ADDR_LENGTH-1:0] addr
  );
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/mci_burst_bridge_line_shifter.sv
// mci_line_shifter: the line buffer of the burst bridge, viewed as BEATS
// beats of EXT_DATA_LENGTH bits (beat 0 = least significant).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load_i         parallel load of load_line_i (request latch)
//   wr_i           write wr_beat_i into beat wr_idx_i (read capture)
//   rd_idx_i       beat presented on rd_beat_o (write data source)
//   line_d_o       next-state line, lets the owner snapshot a completed read
module mci_line_shifter
  import mci_burst_bridge_pkg::*;
#(
  parameter int EXT_DATA_LENGTH = EXT_DATA_LENGTH_DEFAULT,
  parameter int BEATS           = MCI_DATA_LENGTH / EXT_DATA_LENGTH,
  parameter int IW              = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_i,
  input  logic [BEATS*EXT_DATA_LENGTH-1:0] load_line_i,
  input  logic                             wr_i,
  input  logic [IW-1:0]                    wr_idx_i,
  input  logic [EXT_DATA_LENGTH-1:0]       wr_beat_i,
  input  logic [IW-1:0]                    rd_idx_i,
  output logic [EXT_DATA_LENGTH-1:0]       rd_beat_o,
  output logic [BEATS*EXT_DATA_LENGTH-1:0] line_d_o
);

  logic [BEATS-1:0][EXT_DATA_LENGTH-1:0] line_q;
  logic [BEATS-1:0][EXT_DATA_LENGTH-1:0] line_d;

  // Line next-state: load and beat write never coincide (different FSM states).
  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = load_line_i;
    end else if (wr_i) begin
      line_d[wr_idx_i] = wr_beat_i;
    end else begin
      line_d = line_q;
    end
  end

  // Line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_beat_o = line_q[rd_idx_i];
  assign line_d_o  = line_d;

endmodule

// File: rtl/mci_burst_bridge.sv
// mci_burst_bridge: takes one full-line cache request (single-cycle strobe)
// and serializes it into EXT_DATA_LENGTH-wide beats on the external bus.
// Reads are reassembled and answered with a one-cycle mem_res.ready pulse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req             cache request {addr, data, rw, valid}
//   mem_res             cache response {data, ready}
//   ext_valid/ready     external command handshake
//   ext_we/addr/wdata   external command payload
//   ext_rvalid/rdata    external read beats, in command order, no backpressure
module mci_burst_bridge
  import mci_burst_bridge_pkg::*;
#(
  parameter int EXT_DATA_LENGTH = EXT_DATA_LENGTH_DEFAULT,
  parameter int ADDR_LENGTH     = MCI_ADDR_LENGTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  mci_request_t               mem_req,
  output mci_response_t              mem_res,
  output logic                       ext_valid,
  input  logic                       ext_ready,
  output logic                       ext_we,
  output logic [ADDR_LENGTH-1:0]     ext_addr,
  output logic [EXT_DATA_LENGTH-1:0] ext_wdata,
  input  logic                       ext_rvalid,
  input  logic [EXT_DATA_LENGTH-1:0] ext_rdata
);

  localparam int BEATS      = MCI_DATA_LENGTH / EXT_DATA_LENGTH;
  localparam int CW         = $clog2(BEATS) + 1;
  localparam int IW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = EXT_DATA_LENGTH / 8;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cmd_cnt_q, cmd_cnt_d;
  logic [CW-1:0]              rd_cnt_q, rd_cnt_d;
  logic [ADDR_LENGTH-1:0]     base_q, base_d;
  logic                       rw_q, rw_d;
  logic [MCI_DATA_LENGTH-1:0] resp_data_q, resp_data_d;

  logic                       busy;
  logic                       error_req;
  logic                       accept;
  logic                       cmd_hs;
  logic                       rd_cap;
  logic                       read_done;
  logic [EXT_DATA_LENGTH-1:0] beat_wdata;
  logic [MCI_DATA_LENGTH-1:0] line_d;
  ext_cmd_t                   ext_cmd;

  assign busy      = (state_q == SEND) || (state_q == COLLECT);
  // A strobe while a burst is in flight is a protocol violation and is dropped.
  assign error_req = mem_req.valid && busy;
  assign accept    = mem_req.valid && !error_req;
  assign cmd_hs    = (state_q == SEND) && ext_ready;
  // Only beats already commanded can return, so rd_cnt never passes cmd_cnt.
  assign rd_cap    = ext_rvalid && busy && (rd_cnt_q < cmd_cnt_q);

  mci_line_shifter #(
    .EXT_DATA_LENGTH (EXT_DATA_LENGTH),
    .BEATS           (BEATS),
    .IW              (IW)
  ) u_line (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_line_i (mem_req.data),
    .wr_i        (rd_cap),
    .wr_idx_i    (rd_cnt_q[IW-1:0]),
    .wr_beat_i   (ext_rdata),
    .rd_idx_i    (cmd_cnt_q[IW-1:0]),
    .rd_beat_o   (beat_wdata),
    .line_d_o    (line_d)
  );

  // FSM next-state, counters, request latch and read-response snapshot.
  always_comb begin
    state_d   = state_q;
    cmd_cnt_d = cmd_cnt_q + (cmd_hs ? CW'(1) : CW'(0));
    rd_cnt_d  = rd_cnt_q + (rd_cap ? CW'(1) : CW'(0));
    base_d    = base_q;
    rw_d      = rw_q;
    read_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
        else        state_d = IDLE;
      end
      SEND: begin
        if (cmd_hs && (cmd_cnt_q == CW'(BEATS - 1))) begin
          if (rw_q) begin
            state_d = RESP;
          end else if (rd_cnt_d == CW'(BEATS)) begin
            state_d   = RESP;
            read_done = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = SEND;
        end
      end
      COLLECT: begin
        if (rd_cnt_d == CW'(BEATS)) begin
          state_d   = RESP;
          read_done = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      RESP: begin
        // Zero-bubble: a strobe in the response cycle starts the next burst.
        if (accept) state_d = SEND;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      base_d    = line_base(mem_req.addr);
      rw_d      = mem_req.rw;
      cmd_cnt_d = '0;
      rd_cnt_d  = '0;
    end else begin
      base_d = base_q;
    end

    if (read_done) resp_data_d = line_d;
    else           resp_data_d = resp_data_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      base_q      <= '0;
      rw_q        <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_cnt_q   <= cmd_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      base_q      <= base_d;
      rw_q        <= rw_d;
      resp_data_q <= resp_data_d;
    end
  end

  // External command decode; quiet (all zero) outside SEND.
  always_comb begin
    ext_cmd = '0;
    if (state_q == SEND) begin
      ext_cmd.valid = 1'b1;
      ext_cmd.we    = rw_q;
      ext_cmd.addr  = base_q + ADDR_LENGTH'(cmd_cnt_q) * ADDR_LENGTH'(BEAT_BYTES);
      ext_cmd.wdata = beat_wdata;
    end else begin
      ext_cmd = '0;
    end
  end

  assign ext_valid     = ext_cmd.valid;
  assign ext_we        = ext_cmd.we;
  assign ext_addr      = ext_cmd.addr;
  assign ext_wdata     = ext_cmd.wdata;
  assign mem_res.ready = (state_q == RESP);
  assign mem_res.data  = resp_data_q;

endmodule

// File: tb/tb_mci_burst_bridge.sv
// Directed bench for mci_burst_bridge (128-bit line, 32-bit external bus).
module tb_mci_burst_bridge;
  import mci_burst_bridge_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  mci_request_t  req;
  mci_response_t res;
  logic          ext_valid, ext_ready, ext_we, ext_rvalid;
  logic [31:0]   ext_addr, ext_wdata, ext_rdata;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] L1 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] W2 = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
  localparam logic [127:0] W3 = 128'h13131313_12121212_11111111_10101010;
  localparam logic [127:0] L3 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] L5 = 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF;
  localparam logic [127:0] W6 = 128'h66666663_66666662_66666661_66666660;

  always #5 clk = ~clk;

  mci_burst_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (req),
    .mem_res    (res),
    .ext_valid  (ext_valid),
    .ext_ready  (ext_ready),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in the first SEND cycle; memory returns each beat one cycle after
  // its command, so beats arrive alongside later command handshakes.
  task automatic read_burst(input logic [31:0] base, input logic [127:0] line);
    req.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rd_valid", ext_valid, 1'b1);
      chk("rd_we", ext_we, 1'b0);
      chk("rd_addr", ext_addr, base + 32'(4 * k));
      chk("rd_ready_low", res.ready, 1'b0);
      if (k > 0) begin
        ext_rvalid = 1'b1;
        ext_rdata  = line[(k-1)*32 +: 32];
      end else begin
        ext_rvalid = 1'b0;
      end
      step();
    end
    chk("rd_collect_valid", ext_valid, 1'b0);
    chk("rd_collect_ready", res.ready, 1'b0);
    ext_rvalid = 1'b1;
    ext_rdata  = line[96 +: 32];
    step();
    ext_rvalid = 1'b0;
    ext_rdata  = 32'h0;
    chk("rd_ready_pulse", res.ready, 1'b1);
    chk("rd_data", res.data, line);
    step();
    chk("rd_ready_end", res.ready, 1'b0);
    chk("rd_data_hold", res.data, line);
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    ext_ready  = 1'b0;
    ext_rvalid = 1'b0;
    ext_rdata  = 32'h0;
    step();
    step();
    chk("rst_valid", ext_valid, 1'b0);
    chk("rst_we", ext_we, 1'b0);
    chk("rst_addr", ext_addr, 32'h0);
    chk("rst_wdata", ext_wdata, 32'h0);
    chk("rst_ready", res.ready, 1'b0);
    chk("rst_data", res.data, 128'h0);
    rst = 1'b0;
    step();

    // Read line, zero wait, unaligned address.
    ext_ready = 1'b1;
    req.addr = 32'h0000_1234; req.rw = 1'b0; req.data = '0; req.valid = 1'b1;
    step();
    read_burst(32'h0000_1230, L1);

    // Write with two stall cycles before each beat.
    ext_ready = 1'b0;
    req.addr = 32'h80; req.rw = 1'b1; req.data = W2; req.valid = 1'b1;
    step();
    req.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        ext_ready = (s == 2);
        chk("wr_valid", ext_valid, 1'b1);
        chk("wr_we", ext_we, 1'b1);
        chk("wr_addr", ext_addr, 32'h80 + 32'(4 * k));
        chk("wr_wdata", ext_wdata, W2[k*32 +: 32]);
        step();
      end
    end
    ext_ready = 1'b0;
    chk("wr_ready_pulse", res.ready, 1'b1);
    chk("wr_data_unchanged", res.data, L1);
    chk("wr_resp_valid_low", ext_valid, 1'b0);
    step();
    chk("wr_ready_end", res.ready, 1'b0);

    // Write-back then fill strobed in the RESP cycle; write latency BEATS+1.
    ext_ready = 1'b1;
    req.addr = 32'h100; req.rw = 1'b1; req.data = W3; req.valid = 1'b1;
    step();
    req.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wb_addr", ext_addr, 32'h100 + 32'(4 * k));
      chk("wb_wdata", ext_wdata, W3[k*32 +: 32]);
      chk("wb_ready_low", res.ready, 1'b0);
      step();
    end
    chk("wb_ready_latency", res.ready, 1'b1);
    chk("wb_data_unchanged", res.data, L1);
    req.addr = 32'h200; req.rw = 1'b0; req.data = '0; req.valid = 1'b1;
    step();
    read_burst(32'h200, L3);

    // Async reset after two read beats, then a fresh read.
    req.addr = 32'h1000; req.rw = 1'b0; req.valid = 1'b1;
    step();
    req.valid = 1'b0;
    step();
    ext_rvalid = 1'b1; ext_rdata = 32'h5555_0000;
    step();
    ext_rdata = 32'h5555_0001;
    step();
    chk("abort_mid_valid", ext_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst_valid", ext_valid, 1'b0);
    chk("abort_rst_addr", ext_addr, 32'h0);
    chk("abort_rst_we", ext_we, 1'b0);
    chk("abort_rst_wdata", ext_wdata, 32'h0);
    chk("abort_rst_ready", res.ready, 1'b0);
    chk("abort_rst_data", res.data, 128'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("abort_idle_ready", res.ready, 1'b0);
    chk("abort_idle_valid", ext_valid, 1'b0);
    ext_rvalid = 1'b0;
    step();
    chk("abort_no_ready", res.ready, 1'b0);
    req.addr = 32'h40; req.rw = 1'b0; req.valid = 1'b1;
    step();
    read_burst(32'h40, L5);

    // Illegal strobe during SEND.
    req.addr = 32'h300; req.rw = 1'b1; req.data = W6; req.valid = 1'b1;
    #1;
    chk("legal_no_error", dut.error_req, 1'b0);
    step();
    req.addr = 32'h500; req.rw = 1'b0; req.data = {4{32'hFFFF_FFFF}}; req.valid = 1'b1;
    #1;
    chk("illegal_error_req", dut.error_req, 1'b1);
    chk("illegal_addr0", ext_addr, 32'h300);
    step();
    req.valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk("illegal_addr", ext_addr, 32'h300 + 32'(4 * k));
      chk("illegal_we", ext_we, 1'b1);
      chk("illegal_wdata", ext_wdata, W6[k*32 +: 32]);
      step();
    end
    chk("illegal_ready", res.ready, 1'b1);
    chk("illegal_data_unchanged", res.data, L5);
    step();
    chk("illegal_ready_end", res.ready, 1'b0);
    chk("illegal_idle", ext_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
